// File: rtl/cross_product_arbiter.sv
// ---------------------------------------------------------------------------
// signed_vector_cross_product
//   Purely combinational A x B for 57-bit vectors {x,y,z}. Each component is
//   19-bit sign-magnitude {sign, int[8], frac[10]}. Every partial product
//   and every difference saturates to magnitude 18'h3FFFF and keeps its sign.
//   A zero magnitude is always reported with a positive sign.
// Ports:
//   vec_a, vec_b  operands
//   vec_y         cross product
//   sat           some result component has magnitude 18'h3FFFF
// ---------------------------------------------------------------------------
module signed_vector_cross_product (
   input  logic [56:0] vec_a,
   input  logic [56:0] vec_b,
   output logic [56:0] vec_y,
   output logic        sat
);

   // Sign-magnitude multiply: the magnitude product is scaled back by the
   // 10 fraction bits (truncating), then clamped to the 18-bit range.
   function automatic logic [18:0] sm_mul(input logic [18:0] a, input logic [18:0] b);
      logic [35:0] full;
      logic [25:0] scaled;
      logic [17:0] mag;
      full   = {18'b0, a[17:0]} * {18'b0, b[17:0]};
      scaled = 26'(full >> 10);
      mag    = (|scaled[25:18]) ? 18'h3FFFF : scaled[17:0];
      return {(a[18] ^ b[18]) & (|mag), mag};
   endfunction

   // Sign-magnitude subtract p - q. Working in 20-bit two's complement
   // covers the full range of the difference without overflow; the result
   // is converted back to sign-magnitude and clamped.
   function automatic logic [18:0] sm_sub(input logic [18:0] p, input logic [18:0] q);
      logic signed [19:0] ps;
      logic signed [19:0] qs;
      logic signed [19:0] d;
      logic [19:0]        dmag;
      logic [17:0]        mag;
      ps   = p[18] ? -$signed({2'b00, p[17:0]}) : $signed({2'b00, p[17:0]});
      qs   = q[18] ? -$signed({2'b00, q[17:0]}) : $signed({2'b00, q[17:0]});
      d    = ps - qs;
      dmag = d[19] ? 20'(-d) : 20'(d);
      mag  = (|dmag[19:18]) ? 18'h3FFFF : dmag[17:0];
      return {d[19] & (|mag), mag};
   endfunction

   logic [18:0] ax, ay, az, bx, by, bz;
   logic [18:0] cx, cy, cz;

   // Component unpack, the three cross-product terms, and the saturation flag.
   always_comb begin
      {ax, ay, az} = vec_a;
      {bx, by, bz} = vec_b;
      cx    = sm_sub(sm_mul(ay, bz), sm_mul(az, by));
      cy    = sm_sub(sm_mul(az, bx), sm_mul(ax, bz));
      cz    = sm_sub(sm_mul(ax, by), sm_mul(ay, bx));
      vec_y = {cx, cy, cz};
      sat   = (&cx[17:0]) | (&cy[17:0]) | (&cz[17:0]);
   end

endmodule

// ---------------------------------------------------------------------------
// cross_product_arbiter
//   Shares one signed_vector_cross_product between NUM_REQ requesters with
//   round-robin arbitration. The winner's operands are registered, the
//   result is registered and returned on a valid/ready port tagged with the
//   requester index.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   req_valid/req_ready  per-requester handshake (req_ready is one-hot)
//   req_vec_a/req_vec_b  packed operands, requester i at [i*VEC_W +: VEC_W]
//   out_valid/out_ready  result handshake
//   out_vec, out_id      result and owning requester
//   out_sat              some result component saturated
//   op_count             completed result handshakes (wrapping)
//   busy                 FSM not idle
// ---------------------------------------------------------------------------
module cross_product_arbiter #(
   parameter  int NUM_REQ = 4,
   parameter  int ID_W    = 2,
   localparam int VEC_W   = 57
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_REQ-1:0]       req_valid,
   output logic [NUM_REQ-1:0]       req_ready,
   input  logic [NUM_REQ*VEC_W-1:0] req_vec_a,
   input  logic [NUM_REQ*VEC_W-1:0] req_vec_b,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [VEC_W-1:0]         out_vec,
   output logic [ID_W-1:0]          out_id,
   output logic                     out_sat,
   output logic [15:0]              op_count,
   output logic                     busy
);

   typedef enum logic [1:0] {IDLE, CALC, OUT} state_t;

   state_t            state, state_next;
   logic [ID_W-1:0]   last_grant;
   logic [ID_W-1:0]   grant_id;
   logic [ID_W-1:0]   winner;
   logic              any_valid;
   logic              take;
   logic [VEC_W-1:0]  op_a, op_b;
   logic [VEC_W-1:0]  dp_vec;
   logic              dp_sat;

   signed_vector_cross_product u_dp (
      .vec_a (op_a),
      .vec_b (op_b),
      .vec_y (dp_vec),
      .sat   (dp_sat)
   );

   // Round-robin search: start one past the last winner and wrap, so the
   // requester granted most recently is considered last.
   always_comb begin
      int              idx;
      logic [ID_W-1:0] idx_w;
      any_valid = 1'b0;
      winner    = '0;
      idx       = 0;
      idx_w     = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         idx = int'(last_grant) + i;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         idx_w = ID_W'(idx);
         if (!any_valid && req_valid[idx_w]) begin
            any_valid = 1'b1;
            winner    = idx_w;
         end
      end
   end

   // A grant can happen from IDLE, or from OUT in the same cycle the pending
   // result is accepted, which gives back-to-back operation every 2 cycles.
   always_comb begin
      req_ready  = '0;
      take       = 1'b0;
      state_next = state;
      case (state)
         IDLE: begin
            take = any_valid;
            if (any_valid) state_next = CALC;
         end
         CALC: state_next = OUT;
         OUT: begin
            if (out_ready) begin
               take       = any_valid;
               state_next = any_valid ? CALC : IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
      if (take) req_ready[winner] = 1'b1;
   end

   assign busy = (state != IDLE);

   // State, operand capture, result register and handshake counter. Reset
   // discards any in-flight operation.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         last_grant <= ID_W'(NUM_REQ - 1);
         grant_id   <= '0;
         op_a       <= '0;
         op_b       <= '0;
         out_valid  <= 1'b0;
         out_vec    <= '0;
         out_id     <= '0;
         out_sat    <= 1'b0;
         op_count   <= '0;
      end else begin
         state <= state_next;
         if (take) begin
            op_a       <= req_vec_a[int'(winner)*VEC_W +: VEC_W];
            op_b       <= req_vec_b[int'(winner)*VEC_W +: VEC_W];
            grant_id   <= winner;
            last_grant <= winner;
         end
         if (state == CALC) begin
            out_vec   <= dp_vec;
            out_sat   <= dp_sat;
            out_id    <= grant_id;
            out_valid <= 1'b1;
         end
         if (state == OUT && out_ready) begin
            out_valid <= 1'b0;
            op_count  <= op_count + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_cross_product_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cross_product_arbiter
//   Directed bench for cross_product_arbiter: reset values, basic cross
//   product, round-robin order, output back-pressure, saturation, reset
//   mid-operation and negative operands. Expected values are hand-computed.
// ---------------------------------------------------------------------------
module tb_cross_product_arbiter;

   localparam int NUM_REQ = 4;
   localparam int ID_W    = 2;
   localparam int VEC_W   = 57;

   logic                     clk;
   logic                     rst_n;
   logic [NUM_REQ-1:0]       req_valid;
   logic [NUM_REQ-1:0]       req_ready;
   logic [NUM_REQ*VEC_W-1:0] req_vec_a;
   logic [NUM_REQ*VEC_W-1:0] req_vec_b;
   logic                     out_valid;
   logic                     out_ready;
   logic [VEC_W-1:0]         out_vec;
   logic [ID_W-1:0]          out_id;
   logic                     out_sat;
   logic [15:0]              op_count;
   logic                     busy;

   int checks = 0;
   int errors = 0;

   cross_product_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_vec_a (req_vec_a),
      .req_vec_b (req_vec_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_vec   (out_vec),
      .out_id    (out_id),
      .out_sat   (out_sat),
      .op_count  (op_count),
      .busy      (busy)
   );

   // Free-running 10 ns clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [56:0] make_vec(input logic [18:0] x, input logic [18:0] y,
                                            input logic [18:0] z);
      return {x, y, z};
   endfunction

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Load one requester's operand pair.
   task automatic apply_stimulus(input int idx, input logic [56:0] a, input logic [56:0] b);
      req_vec_a[idx*VEC_W +: VEC_W] = a;
      req_vec_b[idx*VEC_W +: VEC_W] = b;
   endtask

   // One counted comparison.
   task automatic check_output(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic apply_reset();
      rst_n     = 1'b0;
      req_valid = '0;
      out_ready = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      #1;
   endtask

   // Directed test sequence.
   initial begin
      rst_n     = 1'b0;
      req_valid = '0;
      out_ready = 1'b0;
      req_vec_a = '0;
      req_vec_b = '0;

      // 1: reset values, then x cross y from requester 0
      apply_reset();
      check_output("rst_out_valid", out_valid, 0);
      check_output("rst_out_vec", out_vec, 0);
      check_output("rst_op_count", op_count, 0);
      check_output("rst_busy", busy, 0);
      apply_stimulus(0, make_vec(19'h00400, 0, 0), make_vec(0, 19'h00400, 0));
      req_valid = 4'b0001;
      #1;
      check_output("t1_req_ready", req_ready, 4'b0001);
      tick();
      req_valid = '0;
      #1;
      check_output("t1_calc_out_valid", out_valid, 0);
      check_output("t1_calc_busy", busy, 1);
      check_output("t1_calc_req_ready", req_ready, 0);
      tick();
      check_output("t1_out_valid", out_valid, 1);
      check_output("t1_out_vec", out_vec, make_vec(0, 0, 19'h00400));
      check_output("t1_out_id", out_id, 0);
      check_output("t1_out_sat", out_sat, 0);
      out_ready = 1'b1;
      tick();
      check_output("t1_op_count", op_count, 1);
      check_output("t1_done_valid", out_valid, 0);

      // 2: all requesters valid, round-robin 0,1,2,3,0; requester i computes (i+1)*x cross y
      apply_reset();
      for (int i = 0; i < NUM_REQ; i++)
         apply_stimulus(i, make_vec(19'((i + 1) * 1024), 0, 0), make_vec(0, 19'h00400, 0));
      out_ready = 1'b1;
      req_valid = 4'b1111;
      #1;
      check_output("t2_first_grant", req_ready, 4'b0001);
      for (int j = 0; j < 5; j++) begin
         tick();
         check_output("t2_calc_valid", out_valid, 0);
         tick();
         check_output("t2_out_valid", out_valid, 1);
         check_output("t2_out_id", out_id, 64'(j % 4));
         check_output("t2_out_vec", out_vec, make_vec(0, 0, 19'(((j % 4) + 1) * 1024)));
         check_output("t2_next_grant", req_ready, 64'(1 << ((j + 1) % 4)));
      end
      req_valid = '0;
      #1;
      tick();
      check_output("t2_op_count", op_count, 5);
      check_output("t2_idle", busy, 0);

      // 3: back-pressure on a pending result from requester 1
      out_ready = 1'b0;
      req_valid = 4'b0110;
      #1;
      check_output("t3_grant1", req_ready, 4'b0010);
      tick();
      tick();
      for (int k = 0; k < 5; k++) begin
         tick();
         check_output("t3_stall_req_ready", req_ready, 0);
         check_output("t3_stall_valid", out_valid, 1);
         check_output("t3_stall_vec", out_vec, make_vec(0, 0, 19'h00800));
         check_output("t3_stall_id", out_id, 1);
         check_output("t3_stall_count", op_count, 5);
      end
      out_ready = 1'b1;
      #1;
      check_output("t3_release_grant2", req_ready, 4'b0100);
      tick();
      check_output("t3_count_after", op_count, 6);
      check_output("t3_valid_after", out_valid, 0);
      req_valid = '0;
      tick();
      check_output("t3_id2", out_id, 2);
      check_output("t3_vec2", out_vec, make_vec(0, 0, 19'h00C00));
      tick();
      check_output("t3_count_final", op_count, 7);

      // 4: 100.0*y cross 100.0*z saturates the x component
      apply_reset();
      apply_stimulus(0, make_vec(0, 19'h19000, 0), make_vec(0, 0, 19'h19000));
      out_ready = 1'b1;
      req_valid = 4'b0001;
      tick();
      req_valid = '0;
      tick();
      check_output("t4_sat_vec", out_vec, make_vec(19'h3FFFF, 0, 0));
      check_output("t4_sat_flag", out_sat, 1);
      tick();
      check_output("t4_count", op_count, 1);

      // 5: reset asserted during CALC, then priority restarts at requester 0
      req_valid = 4'b0010;
      tick();
      req_valid = '0;
      rst_n     = 1'b0;
      #1;
      check_output("t5_rst_valid", out_valid, 0);
      check_output("t5_rst_count", op_count, 0);
      check_output("t5_rst_vec", out_vec, 0);
      check_output("t5_rst_sat", out_sat, 0);
      check_output("t5_rst_busy", busy, 0);
      tick();
      rst_n     = 1'b1;
      req_valid = 4'b1001;
      out_ready = 1'b1;
      #1;
      check_output("t5_grant0", req_ready, 4'b0001);
      tick();
      tick();
      check_output("t5_out_id0", out_id, 0);
      check_output("t5_grant3", req_ready, 4'b1000);
      tick();
      req_valid = '0;
      tick();
      check_output("t5_out_id3", out_id, 3);
      check_output("t5_vec3", out_vec, make_vec(0, 0, 19'h01000));
      tick();

      // 6: negative operand from requester 2: -1.0*x cross y = -1.0*z
      apply_reset();
      apply_stimulus(2, make_vec(19'h40400, 0, 0), make_vec(0, 19'h00400, 0));
      out_ready = 1'b1;
      req_valid = 4'b0100;
      #1;
      check_output("t6_grant2", req_ready, 4'b0100);
      tick();
      req_valid = '0;
      tick();
      check_output("t6_neg_vec", out_vec, make_vec(0, 0, 19'h40400));
      check_output("t6_out_id", out_id, 2);
      check_output("t6_out_sat", out_sat, 0);
      tick();
      check_output("t6_count", op_count, 1);

      $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
